// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, issues one request at a time on the
// SRAM-like instruction bus, and presents the fetched word to the IF/ID register.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [3:0]  stall,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        stallreq_if,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  typedef enum logic [1:0] {StReq, StWait, StReady} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic        discard_q, discard_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  // Only the PC-hold bit of the stall bus matters to this stage.
  logic unused_stall;
  assign unused_stall = ^stall[3:1];

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q     <= StReq;
      pc_q        <= RESET_PC;
      pend_q      <= 1'b0;
      pend_addr_q <= 32'd0;
      discard_q   <= 1'b0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= 32'd0;
      if_inst_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      discard_q   <= discard_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    discard_d   = discard_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;

    if (flush) begin
      // Flush wins over any same-cycle jump; an in-flight read is marked for discard.
      pend_d = 1'b0;
      pc_d   = flush_addr;
      unique case (state_q)
        StReq: begin
          if (inst_addr_ok) begin
            state_d   = StWait;
            discard_d = 1'b1;
          end
        end
        StWait: begin
          if (inst_data_ok) begin
            state_d   = StReq;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end
        StReady: begin
          if_valid_d = 1'b0;
          state_d    = StReq;
        end
        default: state_d = StReq;
      endcase
    end else begin
      if (jump_en) begin
        pend_d      = 1'b1;
        pend_addr_d = jump_addr;
      end
      unique case (state_q)
        StReq: begin
          if (inst_addr_ok) state_d = StWait;
        end
        StWait: begin
          if (inst_data_ok) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = StReq;
            end else begin
              if_inst_d  = inst_rdata;
              if_pc_d    = pc_q;
              if_valid_d = 1'b1;
              state_d    = StReady;
            end
          end
        end
        StReady: begin
          if (!stall[0]) begin
            // The word in IF is the delay slot; the jump target applies to the next PC.
            if (jump_en)     pc_d = jump_addr;
            else if (pend_q) pc_d = pend_addr_q;
            else             pc_d = pc_q + 32'd4;
            pend_d     = 1'b0;
            if_valid_d = 1'b0;
            state_d    = StReq;
          end
        end
        default: state_d = StReq;
      endcase
    end
  end

  assign inst_req    = ~cpu_rst & (state_q == StReq);
  assign stallreq_if = ~cpu_rst & ((state_q == StReq) | (state_q == StWait));
  assign inst_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_pc       = if_pc_q;
  assign if_inst     = if_inst_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: table-driven fetch vectors with a scoreboard,
// plus hand sequences for flush, jump, wrap and reset corner cases.
module tb_if_fetch;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [3:0]  stall;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        flush;
  logic [31:0] flush_addr;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        stallreq_if;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  if_fetch dut (
    .cpu_clk      (cpu_clk),
    .cpu_rst      (cpu_rst),
    .stall        (stall),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .flush        (flush),
    .flush_addr   (flush_addr),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .stallreq_if  (stallreq_if),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    int unsigned aw;
    int unsigned dw;
    logic [31:0] rdata;
    int unsigned stall_cyc;
    bit          jmp;
    logic [31:0] jaddr;
    logic [31:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  vec_t vecs[5];
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (inst_req !== 1'b1 && n < 20) begin
      @(negedge cpu_clk);
      n++;
    end
    chk("req_seen", {31'd0, inst_req}, 32'd1);
  endtask

  task automatic mk(input vec_t v, output exp_t e);
    e.pc   = v.exp_addr;
    e.inst = v.rdata;
  endtask

  // Run one transaction from REQ through to the first READY cycle.
  task automatic get_ready(input vec_t v);
    exp_t e;
    wait_req();
    chk("req_addr", inst_addr, v.exp_addr);
    chk("req_stallreq", {31'd0, stallreq_if}, 32'd1);
    if (v.jmp) begin
      jump_en   = 1'b1;
      jump_addr = v.jaddr;
    end
    for (int i = 0; i < int'(v.aw); i++) begin
      @(negedge cpu_clk);
      jump_en = 1'b0;
      chk("req_hold_addr", inst_addr, v.exp_addr);
      chk("req_hold_stallreq", {31'd0, stallreq_if}, 32'd1);
    end
    inst_addr_ok = 1'b1;
    @(negedge cpu_clk);
    inst_addr_ok = 1'b0;
    jump_en      = 1'b0;
    chk("wait_req_low", {31'd0, inst_req}, 32'd0);
    chk("wait_stallreq", {31'd0, stallreq_if}, 32'd1);
    chk("wait_addr", inst_addr, v.exp_addr);
    for (int i = 0; i < int'(v.dw); i++) begin
      @(negedge cpu_clk);
      chk("wait_hold_stallreq", {31'd0, stallreq_if}, 32'd1);
      chk("wait_hold_valid", {31'd0, if_valid}, 32'd0);
    end
    inst_data_ok = 1'b1;
    inst_rdata   = v.rdata;
    mk(v, e);
    sb.push_back(e);
    @(negedge cpu_clk);
    inst_data_ok = 1'b0;
    inst_rdata   = $urandom;
    chk("ready_valid", {31'd0, if_valid}, 32'd1);
    chk("ready_stallreq", {31'd0, stallreq_if}, 32'd0);
    chk("ready_req", {31'd0, inst_req}, 32'd0);
    if (sb.size() > 0) begin
      last_exp = sb.pop_front();
      chk("if_pc", if_pc, last_exp.pc);
      chk("if_inst", if_inst, last_exp.inst);
    end
  endtask

  task automatic hold(input int unsigned cyc);
    stall = (cyc > 0) ? 4'b0001 : 4'b0000;
    for (int i = 0; i < int'(cyc); i++) begin
      @(negedge cpu_clk);
      chk("hold_valid", {31'd0, if_valid}, 32'd1);
      chk("hold_pc", if_pc, last_exp.pc);
      chk("hold_inst", if_inst, last_exp.inst);
      chk("hold_req", {31'd0, inst_req}, 32'd0);
    end
    stall = 4'b0000;
  endtask

  task automatic fetch(input vec_t v);
    get_ready(v);
    hold(v.stall_cyc);
  endtask

  function automatic vec_t fv(input logic [31:0] a, input logic [31:0] d);
    vec_t v;
    v.aw = 0; v.dw = 0; v.rdata = d; v.stall_cyc = 0;
    v.jmp = 1'b0; v.jaddr = 32'd0; v.exp_addr = a;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{aw: 0, dw: 0, rdata: 32'h2408_0001, stall_cyc: 0, jmp: 1'b0,
                jaddr: 32'd0, exp_addr: 32'hBFC0_0000};
    vecs[1] = '{aw: 0, dw: 0, rdata: 32'h1111_1111, stall_cyc: 5, jmp: 1'b0,
                jaddr: 32'd0, exp_addr: 32'hBFC0_0004};
    vecs[2] = '{aw: 3, dw: 3, rdata: 32'h2222_2222, stall_cyc: 0, jmp: 1'b1,
                jaddr: 32'hBFC0_0100, exp_addr: 32'hBFC0_0008};
    vecs[3] = '{aw: 1, dw: 1, rdata: 32'h3333_3333, stall_cyc: 2, jmp: 1'b0,
                jaddr: 32'd0, exp_addr: 32'hBFC0_0100};
    vecs[4] = '{aw: 0, dw: 0, rdata: 32'h4444_4444, stall_cyc: 1, jmp: 1'b0,
                jaddr: 32'd0, exp_addr: 32'hBFC0_0104};

    cpu_rst = 1'b1; stall = 4'hF; jump_en = 1'b0; jump_addr = 32'd0;
    flush = 1'b0; flush_addr = 32'd0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    inst_rdata = 32'd0;
    repeat (3) @(negedge cpu_clk);
    chk("rst_req", {31'd0, inst_req}, 32'd0);
    chk("rst_stallreq", {31'd0, stallreq_if}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_addr", inst_addr, 32'hBFC0_0000);
    cpu_rst = 1'b0;
    stall   = 4'h0;

    for (int i = 0; i < 5; i++) fetch(vecs[i]);

    // Flush during WAIT, data arrives two cycles later; earlier pending jump is dropped.
    wait_req();
    chk("fw_addr", inst_addr, 32'hBFC0_0108);
    jump_en = 1'b1; jump_addr = 32'hBFC0_0200; inst_addr_ok = 1'b1;
    @(negedge cpu_clk);
    jump_en = 1'b0; inst_addr_ok = 1'b0;
    flush = 1'b1; flush_addr = 32'hBFC0_0380;
    @(negedge cpu_clk);
    flush = 1'b0;
    chk("fw_valid0", {31'd0, if_valid}, 32'd0);
    @(negedge cpu_clk);
    chk("fw_valid1", {31'd0, if_valid}, 32'd0);
    inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    @(negedge cpu_clk);
    inst_data_ok = 1'b0;
    chk("fw_valid2", {31'd0, if_valid}, 32'd0);
    chk("fw_req", {31'd0, inst_req}, 32'd1);
    chk("fw_newaddr", inst_addr, 32'hBFC0_0380);
    fetch(fv(32'hBFC0_0380, 32'h5555_0001));
    fetch(fv(32'hBFC0_0384, 32'h5555_0002));

    // Flush plus jump in READY while stalled; then PC wrap past 2^32.
    get_ready(fv(32'hBFC0_0388, 32'h6666_0001));
    stall = 4'b0001; flush = 1'b1; flush_addr = 32'hFFFF_FFFC;
    jump_en = 1'b1; jump_addr = 32'hBFC0_0500;
    @(negedge cpu_clk);
    flush = 1'b0; jump_en = 1'b0; stall = 4'b0000;
    chk("fr_valid", {31'd0, if_valid}, 32'd0);
    chk("fr_req", {31'd0, inst_req}, 32'd1);
    chk("fr_addr", inst_addr, 32'hFFFF_FFFC);
    fetch(fv(32'hFFFF_FFFC, 32'h7777_0001));
    fetch(fv(32'h0000_0000, 32'h7777_0002));

    // Flush in REQ without accept: address changes, misalignment passes through.
    wait_req();
    chk("fq_addr", inst_addr, 32'h0000_0004);
    flush = 1'b1; flush_addr = 32'h1234_5679;
    @(negedge cpu_clk);
    flush = 1'b0;
    chk("fq_req", {31'd0, inst_req}, 32'd1);
    chk("fq_newaddr", inst_addr, 32'h1234_5679);
    fetch(fv(32'h1234_5679, 32'h8888_0001));

    // Flush in REQ together with accept: returning data is dropped.
    wait_req();
    chk("fa_addr", inst_addr, 32'h1234_567D);
    flush = 1'b1; flush_addr = 32'hBFC0_0400; inst_addr_ok = 1'b1;
    @(negedge cpu_clk);
    flush = 1'b0; inst_addr_ok = 1'b0;
    chk("fa_wait_req", {31'd0, inst_req}, 32'd0);
    chk("fa_wait_stallreq", {31'd0, stallreq_if}, 32'd1);
    inst_data_ok = 1'b1; inst_rdata = 32'hBAD0_0001;
    @(negedge cpu_clk);
    inst_data_ok = 1'b0;
    chk("fa_valid", {31'd0, if_valid}, 32'd0);
    chk("fa_req", {31'd0, inst_req}, 32'd1);
    chk("fa_newaddr", inst_addr, 32'hBFC0_0400);

    // Flush in WAIT coinciding with data_ok.
    inst_addr_ok = 1'b1;
    @(negedge cpu_clk);
    inst_addr_ok = 1'b0;
    flush = 1'b1; flush_addr = 32'hBFC0_0600; inst_data_ok = 1'b1; inst_rdata = 32'hBAD0_0002;
    @(negedge cpu_clk);
    flush = 1'b0; inst_data_ok = 1'b0;
    chk("fd_valid", {31'd0, if_valid}, 32'd0);
    chk("fd_req", {31'd0, inst_req}, 32'd1);
    chk("fd_newaddr", inst_addr, 32'hBFC0_0600);
    fetch(fv(32'hBFC0_0600, 32'h9999_0001));

    // Reset mid-transaction with stall asserted.
    wait_req();
    chk("rm_addr", inst_addr, 32'hBFC0_0604);
    inst_addr_ok = 1'b1;
    @(negedge cpu_clk);
    inst_addr_ok = 1'b0;
    cpu_rst = 1'b1; stall = 4'b0001;
    @(negedge cpu_clk);
    chk("rm_req", {31'd0, inst_req}, 32'd0);
    chk("rm_stallreq", {31'd0, stallreq_if}, 32'd0);
    chk("rm_valid", {31'd0, if_valid}, 32'd0);
    chk("rm_addr_rst", inst_addr, 32'hBFC0_0000);
    cpu_rst = 1'b0; stall = 4'b0000;
    fetch(fv(32'hBFC0_0000, 32'hAAAA_0001));
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
